// File: rtl/handle_pkg.sv
// rtl/handle_pkg.sv - shared widths, codes, FSM states and address helper for the handle sequencer
// Contents: default widths, bus op codes, request cmd codes, response err codes,
// FSM state enum, and h_op() which builds the handle-command bus address.
package handle_pkg;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_HNDL_WIDTH = 3;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;

  localparam logic [1:0] CMD_ALLOC = 2'd1;
  localparam logic [1:0] CMD_FREE  = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NO_FREE = 2'd1;
  localparam logic [1:0] ERR_BAD_ARG = 2'd2;
  localparam logic [1:0] ERR_STATE   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_MAP,
    S_FREE,
    S_RESP
  } state_t;

  // Top bit plus the next HNDL_WIDTH bits set select the handle-command
  // window; the id sits in the low bits and everything between is zero.
  function automatic logic [DEF_ADDR_WIDTH-1:0] h_op(input logic [DEF_HNDL_WIDTH-1:0] id);
    logic [DEF_ADDR_WIDTH-1:0] a;
    a = '0;
    a[DEF_ADDR_WIDTH-1 -: DEF_HNDL_WIDTH+1] = '1;
    a[DEF_HNDL_WIDTH-1:0] = id;
    return a;
  endfunction

endpackage

// File: rtl/handle_shadow_map.sv
// rtl/handle_shadow_map.sv - local bitmap of handle ids this initiator believes are allocated
// Ports:
//   clock, reset_n      clock and synchronous active-low reset (clears the bitmap)
//   set_en, clr_en      set / clear the bit addressed by upd_id
//   upd_id              id to update
//   lookup_id, hit      combinational lookup of one bit
module handle_shadow_map
  import handle_pkg::*;
#(
  parameter int HNDL_WIDTH = DEF_HNDL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic                  clr_en,
  input  logic [HNDL_WIDTH-1:0] upd_id,
  input  logic [HNDL_WIDTH-1:0] lookup_id,
  output logic                  hit
);

  logic [2**HNDL_WIDTH-1:0] bitmap;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bitmap <= '0;
    end else begin
      if (set_en) bitmap[upd_id] <= 1'b1;
      if (clr_en) bitmap[upd_id] <= 1'b0;
    end
  end

  assign hit = bitmap[lookup_id];

endmodule

// File: rtl/handle_alloc_master.sv
// rtl/handle_alloc_master.sv - sequences core ALLOC/FREE requests into handle-command bus ops
// Optional feature macro: HANDLE_SHADOW_EN (local allocated bitmap, enables err STATE).
// Ports:
//   i_clock, i_reset_n                        clock, synchronous active-low reset
//   i_req_valid/o_req_ready, i_req_cmd,
//   i_req_base, i_req_id                      request channel (1 = ALLOC, 2 = FREE)
//   o_rsp_valid/i_rsp_ready, o_rsp_id,
//   o_rsp_err                                 response channel (0 OK,1 NO_FREE,2 BAD_ARG,3 STATE)
//   o_op, o_address, o_data, i_data           handle-command bus (one cycle per op)
module handle_alloc_master
  import handle_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int HNDL_WIDTH = DEF_HNDL_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_cmd,
  input  logic [ADDR_WIDTH-1:0] i_req_base,
  input  logic [HNDL_WIDTH-1:0] i_req_id,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [HNDL_WIDTH-1:0] o_rsp_id,
  output logic [1:0]            o_rsp_err,
  output logic [2:0]            o_op,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [ADDR_WIDTH-1:0] o_data,
  input  logic [ADDR_WIDTH-1:0] i_data
);

  localparam logic [HNDL_WIDTH-1:0] ID_NONE = '1;

  function automatic logic [ADDR_WIDTH-1:0] cmd_addr(input logic [HNDL_WIDTH-1:0] id);
    return ADDR_WIDTH'(h_op(DEF_HNDL_WIDTH'(id)));
  endfunction

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [HNDL_WIDTH-1:0] id_q;

  logic                  accept;
  logic                  base_bad;
  logic [HNDL_WIDTH-1:0] query_id;
  logic                  free_conflict;
  logic                  alloc_conflict;
  logic                  unused_data;

  assign accept   = i_req_valid & o_req_ready;
  assign base_bad = (i_req_base == '0) || (|i_req_base[ADDR_WIDTH-1 -: HNDL_WIDTH]);
  assign query_id = i_data[HNDL_WIDTH-1:0];
  // Only the id field of the query return is meaningful.
  assign unused_data = ^i_data[ADDR_WIDTH-1:HNDL_WIDTH];

`ifdef HANDLE_SHADOW_EN
  logic [HNDL_WIDTH-1:0] lookup_id;
  logic                  shadow_hit;

  // In IDLE the lookup checks the FREE target; in QUERY it checks the id
  // the handler just offered, so one read port serves both decisions.
  assign lookup_id = (state == S_QUERY) ? query_id : i_req_id;

  handle_shadow_map #(.HNDL_WIDTH(HNDL_WIDTH)) u_shadow (
    .clock     (i_clock),
    .reset_n   (i_reset_n),
    .set_en    (state == S_MAP),
    .clr_en    (state == S_FREE),
    .upd_id    (id_q),
    .lookup_id (lookup_id),
    .hit       (shadow_hit)
  );

  assign free_conflict  = ~shadow_hit;
  assign alloc_conflict = shadow_hit;
`else
  assign free_conflict  = 1'b0;
  assign alloc_conflict = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      id_q        <= '0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_err   <= ERR_OK;
      o_op        <= OP_NOP;
      o_address   <= '0;
      o_data      <= '0;
    end else begin
      // Bus commands are single-cycle: every state that issues one sets
      // it on entry, and it falls back to NOP here on the following edge.
      o_op      <= OP_NOP;
      o_address <= '0;
      o_data    <= '0;
      unique case (state)
        S_IDLE: begin
          o_req_ready <= 1'b1;
          if (accept) begin
            o_req_ready <= 1'b0;
            base_q      <= i_req_base;
            id_q        <= i_req_id;
            if (i_req_cmd == CMD_ALLOC && !base_bad) begin
              state     <= S_QUERY;
              o_op      <= OP_READ;
              o_address <= cmd_addr(ID_NONE);
            end else if (i_req_cmd == CMD_FREE && i_req_id != ID_NONE) begin
              if (free_conflict) begin
                state       <= S_RESP;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= ERR_STATE;
              end else begin
                state     <= S_FREE;
                o_op      <= OP_WRITE;
                o_address <= cmd_addr(i_req_id);
              end
            end else begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= ERR_BAD_ARG;
            end
          end
        end
        S_QUERY: begin
          id_q <= query_id;
          if (query_id == ID_NONE || alloc_conflict) begin
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= (query_id == ID_NONE) ? ERR_NO_FREE : ERR_STATE;
          end else begin
            state     <= S_MAP;
            o_op      <= OP_WRITE;
            o_address <= cmd_addr(query_id);
            o_data    <= base_q;
          end
        end
        S_MAP, S_FREE: begin
          state       <= S_RESP;
          o_rsp_valid <= 1'b1;
          o_rsp_id    <= id_q;
          o_rsp_err   <= ERR_OK;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            state       <= S_IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_err   <= ERR_OK;
            o_req_ready <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handle_alloc_master.sv
// tb/tb_handle_alloc_master.sv - randomized self-checking bench for handle_alloc_master
module tb_handle_alloc_master;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [1:0]  i_req_cmd;
  logic [63:0] i_req_base;
  logic [2:0]  i_req_id;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [2:0]  o_rsp_id;
  logic [1:0]  o_rsp_err;
  logic [2:0]  o_op;
  logic [63:0] o_address;
  logic [63:0] o_data;
  logic [63:0] i_data;

`ifdef HANDLE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit amap [8];

  handle_alloc_master dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_cmd   (i_req_cmd),
    .i_req_base  (i_req_base),
    .i_req_id    (i_req_id),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_err   (o_rsp_err),
    .o_op        (o_op),
    .o_address   (o_address),
    .o_data      (o_data),
    .i_data      (i_data)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hop(input logic [2:0] id);
    return 64'hF000_0000_0000_0000 + 64'(id);
  endfunction

  task automatic chk_bus(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    chk({tag, "_op"}, 64'(o_op), 64'(op));
    chk({tag, "_addr"}, o_address, a);
    chk({tag, "_data"}, o_data, d);
  endtask

  // One request from acceptance through response handshake; called at a
  // negedge with the DUT idle.
  task automatic run_txn(input logic [1:0] cmd, input logic [63:0] base, input logic [2:0] id,
                         input logic [2:0] rdata, input int hold);
    int          lat;
    logic [1:0]  eerr;
    logic [2:0]  eid;
    bit          rd, wr;
    logic [63:0] waddr, wdata, d;
    rd = 1'b0; wr = 1'b0; eid = '0; waddr = '0; wdata = '0;
    if (cmd == 2'd1 && base != 64'd0 && base[63:61] == 3'b000) begin
      rd = 1'b1;
      if (rdata == 3'd7) begin
        eerr = 2'd1; lat = 2;
      end else if (SHADOW && amap[rdata]) begin
        eerr = 2'd3; lat = 2;
      end else begin
        wr = 1'b1; waddr = hop(rdata); wdata = base; eerr = 2'd0; eid = rdata; lat = 3;
        amap[rdata] = 1'b1;
      end
    end else if (cmd == 2'd2 && id != 3'd7) begin
      if (SHADOW && !amap[id]) begin
        eerr = 2'd3; lat = 1;
      end else begin
        wr = 1'b1; waddr = hop(id); wdata = 64'd0; eerr = 2'd0; eid = id; lat = 2;
        amap[id] = 1'b0;
      end
    end else begin
      eerr = 2'd2; lat = 1;
    end

    chk("idle_ready", 64'(o_req_ready), 64'd1);
    d = {$urandom, $urandom};
    d[2:0] = rdata;
    i_req_valid = 1'b1; i_req_cmd = cmd; i_req_base = base; i_req_id = id;
    i_data = d; i_rsp_ready = 1'($urandom_range(0, 1));
    @(posedge i_clock);
    for (int k = 1; k <= lat; k++) begin
      @(negedge i_clock);
      if (k < lat) begin
        chk("busy_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("busy_req_ready", 64'(o_req_ready), 64'd0);
        if (rd && k == 1)
          chk_bus("query", 3'd1, hop(3'd7), 64'd0);
        else if (wr && k == lat - 1)
          chk_bus("write", 3'd2, waddr, wdata);
        else
          chk_bus("gap", 3'd0, 64'd0, 64'd0);
      end else begin
        chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
        chk("rsp_err", 64'(o_rsp_err), 64'(eerr));
        if (eerr == 2'd0) chk("rsp_id", 64'(o_rsp_id), 64'(eid));
        chk("rsp_req_ready", 64'(o_req_ready), 64'd0);
        chk_bus("rsp", 3'd0, 64'd0, 64'd0);
      end
      // Garbage on the request side while busy must be ignored.
      i_req_valid = 1'($urandom_range(0, 1));
      i_req_cmd   = 2'($urandom);
      i_req_base  = {$urandom, $urandom};
      i_req_id    = 3'($urandom);
      i_rsp_ready = (k == lat) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clock);
      chk("hold_valid", 64'(o_rsp_valid), 64'd1);
      chk("hold_err", 64'(o_rsp_err), 64'(eerr));
      if (eerr == 2'd0) chk("hold_id", 64'(o_rsp_id), 64'(eid));
      chk("hold_req_ready", 64'(o_req_ready), 64'd0);
      chk("hold_op", 64'(o_op), 64'd0);
    end
    // A request offered at the handshake edge must not be taken.
    i_rsp_ready = 1'b1;
    i_req_valid = 1'b1; i_req_cmd = 2'd2; i_req_id = 3'd0;
    @(negedge i_clock);
    chk("post_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("post_req_ready", 64'(o_req_ready), 64'd1);
    chk("post_op", 64'(o_op), 64'd0);
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]  cmd;
    logic [63:0] base;
    i_reset_n = 1'b0; i_req_valid = 1'b0; i_req_cmd = '0; i_req_base = '0;
    i_req_id = '0; i_rsp_ready = 1'b0; i_data = '0;
    foreach (amap[i]) amap[i] = 1'b0;

    repeat (3) begin
      @(negedge i_clock);
      chk("rst_req_ready", 64'(o_req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk_bus("rst", 3'd0, 64'd0, 64'd0);
    end
    i_reset_n = 1'b1;
    @(negedge i_clock);
    chk("rel_req_ready", 64'(o_req_ready), 64'd1);
    chk("rel_rsp_valid", 64'(o_rsp_valid), 64'd0);

    // Reset during MAP drops the request.
    i_req_valid = 1'b1; i_req_cmd = 2'd1; i_req_base = 64'h40; i_data = 64'h5;
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid = 1'b0;
    chk("mr_query_op", 64'(o_op), 64'd1);
    @(negedge i_clock);
    chk_bus("mr_map", 3'd2, hop(3'd5), 64'h40);
    i_reset_n = 1'b0;
    @(negedge i_clock);
    chk_bus("mr_reset", 3'd0, 64'd0, 64'd0);
    chk("mr_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("mr_req_ready", 64'(o_req_ready), 64'd0);
    i_reset_n = 1'b1;
    foreach (amap[i]) amap[i] = 1'b0;
    repeat (2) begin
      @(negedge i_clock);
      chk("mr_after_valid", 64'(o_rsp_valid), 64'd0);
      chk("mr_after_op", 64'(o_op), 64'd0);
    end

    run_txn(2'd1, 64'h10, 3'd0, 3'd2, 0);
    run_txn(2'd2, 64'h0, 3'd2, 3'd0, 1);
    run_txn(2'd1, 64'h10, 3'd0, 3'd7, 0);
    run_txn(2'd1, 64'h0, 3'd0, 3'd2, 0);
    run_txn(2'd1, 64'h2000_0000_0000_0000, 3'd0, 3'd2, 0);
    run_txn(2'd1, 64'h10, 3'd0, 3'd2, 5);
    run_txn(2'd2, 64'h0, 3'd3, 3'd0, 0);
    run_txn(2'd0, 64'h10, 3'd1, 3'd1, 0);
    run_txn(2'd3, 64'h10, 3'd1, 3'd1, 0);
    run_txn(2'd2, 64'h0, 3'd7, 3'd0, 0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: cmd = 2'd1;
        5, 6, 7:       cmd = 2'd2;
        default:       cmd = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      endcase
      case ($urandom_range(0, 3))
        0:       base = 64'd0;
        1:       base = {$urandom, $urandom};
        default: base = {3'b000, 29'($urandom), $urandom};
      endcase
      run_txn(cmd, base, 3'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handle_alloc_master.md
# handle_alloc_master

Initiator-side sequencer for the object-handle translation unit. Accepts ALLOC/FREE requests from the core over a valid/ready channel and turns each into the handle-command bus sequence the handle handler expects:
- free-id query read;
- map write or invalidate write.

It returns the allocated handle id or an error code on a valid/ready response channel. It sits between the core's allocator hook and the handle handler's `op`/`address`/`data` inputs.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, bus address/data width
- `HNDL_WIDTH`, 3, handle id width; the all-ones id is the reserved query/none code

Ports:
- `i_clock`  in  1  clock
- `i_reset_n`  in  1  synchronous, active-low reset
- `i_req_valid`  in  1  request valid
- `o_req_ready`  out  1  request ready
- `i_req_cmd`  in  2  1 = ALLOC, 2 = FREE; 0 and 3 are illegal
- `i_req_base`  in  ADDR_WIDTH  ALLOC base address
- `i_req_id`  in  HNDL_WIDTH  FREE target id
- `o_rsp_valid`  out  1  response valid
- `i_rsp_ready`  in  1  response ready
- `o_rsp_id`  out  HNDL_WIDTH  allocated or freed id
- `o_rsp_err`  out  2  0 OK, 1 NO_FREE, 2 BAD_ARG, 3 STATE
- `o_op`  out  3  bus op: 0 NOP, 1 READ, 2 WRITE
- `o_address`  out  ADDR_WIDTH  bus address
- `o_data`  out  ADDR_WIDTH  bus write data
- `i_data`  in  ADDR_WIDTH  handler read-return data, valid in the same cycle as READ

## Operation
- Handle-command address `H_OP(id)` is built as follows:
  - bit `ADDR_WIDTH-1` = 1;
  - bits `[ADDR_WIDTH-2:ADDR_WIDTH-HNDL_WIDTH-1]` all ones;
  - low `HNDL_WIDTH` bits = id;
  - all other bits 0.
- FSM states and transitions:
  - IDLE:
    - `o_req_ready` = 1.
    - On handshake, register the request.
    - ALLOC goes to QUERY.
    - FREE goes to FREE.
    - Illegal cmd, or an argument that fails the BAD_ARG check below, goes to RESP with err 2.
  - BAD_ARG conditions:
    - ALLOC with `i_req_base` == 0;
    - ALLOC with any of `i_req_base[ADDR_WIDTH-1:ADDR_WIDTH-HNDL_WIDTH]` set;
    - FREE with `i_req_id` all ones.
  - QUERY:
    - Drive `o_op`=READ, `o_address`=`H_OP(all ones)`, `o_data`=0.
    - Capture `i_data[HNDL_WIDTH-1:0]` at the closing edge.
    - If the captured id is all ones, go to RESP with err 1.
    - Otherwise go to MAP.
  - MAP:
    - Drive WRITE, `o_address`=`H_OP(captured id)`, `o_data`=base.
    - Go to RESP with err 0 and `o_rsp_id` = captured id.
  - FREE:
    - Drive WRITE, `o_address`=`H_OP(i_req_id)`, `o_data`=0.
    - Go to RESP with err 0 and `o_rsp_id` = `i_req_id`.
  - RESP:
    - `o_rsp_valid` = 1, holding id and err stable.
    - Return to IDLE on `i_rsp_ready`.
- Outside QUERY/MAP/FREE, `o_op`, `o_address` and `o_data` are all 0. Each bus command lasts exactly one cycle.
- Only one request is in flight at a time. `o_req_ready` is 0 in every state except IDLE.
- BAD_ARG and every RESP-only path issue no bus operation.

## Timing
- Reset values: `o_req_ready` = 0 during reset, then 1 in IDLE from the first cycle after reset release. All other outputs are 0. FSM = IDLE.
- ALLOC latency:
  - accept edge;
  - QUERY cycle;
  - MAP cycle;
  - `o_rsp_valid` asserted on the 3rd cycle after accept.
- NO_FREE: `o_rsp_valid` on the 2nd cycle after accept.
- FREE: `o_rsp_valid` on the 2nd cycle after accept.
- BAD_ARG: `o_rsp_valid` on the 1st cycle after accept.
- Response handshake completing at edge N: IDLE (ready = 1) during cycle N+1. There is no same-cycle response-to-accept bypass.
- Back-pressure: RESP holds indefinitely and the bus stays NOP.
- Reset mid-sequence: the FSM returns to IDLE and the bus goes to NOP at the next edge. The pending request is dropped with no response.

## Configuration
- `HANDLE_SHADOW_EN`: when defined, keeps a local `2**HNDL_WIDTH`-bit allocated bitmap.
  - Bitmap reset value is 0.
  - A bit is set on ALLOC OK and cleared on FREE OK.
  - FREE of a clear bit goes IDLE to RESP with err 3 and no bus op.
  - ALLOC whose captured id is already set goes QUERY to RESP with err 3, skips MAP, and leaves the bitmap unchanged.
- When not defined: there is no bitmap, err 3 is never produced, and FREE always issues its write.

## Structure
- Package `handle_pkg` holds:
  - `ADDR_WIDTH` and `HNDL_WIDTH` defaults;
  - op codes NOP/READ/WRITE;
  - cmd codes ALLOC/FREE;
  - err codes;
  - FSM state enum;
  - function `h_op(id)`.
- Sub-module `handle_shadow_map`:
  - ports for the set/clear strobes, lookup id, and hit output;
  - instantiated only under `HANDLE_SHADOW_EN`.

## Test plan
All scenarios use defaults (ADDR_WIDTH 64, HNDL_WIDTH 3).
1. ALLOC with base 0x10 and the bench returning `i_data`=2 during READ. Required response:
   - READ at 0xF000000000000007, then WRITE at 0xF000000000000002 with data 0x10;
   - rsp id 2, err 0, 3 cycles after accept.
2. FREE with id 2. Required response: WRITE at 0xF000000000000002 with data 0; rsp id 2, err 0, 2 cycles after accept.
3. ALLOC with `i_data`=7 returned. Required response: no WRITE; err 1, 2 cycles after accept.
4. ALLOC with base 0, and separately ALLOC with base 0x2000000000000000. Required response: err 2 after 1 cycle; `o_op` stays 0 throughout.
5. Hold `i_rsp_ready`=0 for 5 cycles after the scenario 1 response. Required response:
   - rsp holds stable;
   - `o_req_ready`=0;
   - bus NOP;
   - a new request is accepted only in the cycle after the response handshake.
6. `HANDLE_SHADOW_EN` defined:
   - FREE id 3 with nothing allocated: err 3, no bus op.
   - Deassert `i_reset_n` in MAP: next cycle IDLE, all outputs 0, bitmap cleared.
